// File: rtl/rr_arb_pkg.sv
// Shared types and the rotate-priority pick function for the 4-way round-robin arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // First set bit scanning ptr, ptr+1, ... with natural IDX_W-bit wrap.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = p + IDX_W'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/arb_grant_dec.sv
// Combinational 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module arb_grant_dec
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered owner index and back-to-back handover.
// Optional per-owner hold limit compiled in with `define ARB_HOLD_LIMIT_EN.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_cfg
        $error("rr_arbiter_4: MAX_HOLD/CNT_W out of range");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] nxt_ptr;
    logic [NUM_REQ-1:0] others;
    logic             handover;
`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;
    assign nxt_ptr   = idx_q + 1'b1;
    // In GRANT, gnt is exactly the owner bit, so this masks out the owner.
    assign others    = req & ~gnt;

    arb_grant_dec u_dec (
        .idx    (idx_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        handover = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = pick(req, ptr_q);
                    state_d = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (req[idx_q]) begin
`ifdef ARB_HOLD_LIMIT_EN
                    if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                        if (|others) handover = 1'b1;
                        else         cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end else if (|others) begin
                    handover = 1'b1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ptr_d   = nxt_ptr;
                end
                // Release and forced hand-off share one rule: releaser drops to lowest priority.
                if (handover) begin
                    ptr_d = nxt_ptr;
                    idx_d = pick(req, nxt_ptr);
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus random req against a behavioural owner/pointer model.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_chk = 0;
    int n_bad = 0;

    // Model: owner is -1 when idle; ptr and hold are plain integers.
    int m_own = -1;
    int m_ptr = 0;
    int m_hold = 0;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic rs);
        logic [3:0] rest;
        bit         pass_on;
        if (rs) begin
            m_own = -1; m_ptr = 0; m_hold = 0;
        end else if (m_own < 0) begin
            if (r != 0) begin
                m_own  = first_from(r, m_ptr);
                m_hold = 0;
            end
        end else begin
            rest    = r;
            rest[m_own] = 1'b0;
            pass_on = 1'b0;
            if (r[m_own]) begin
`ifdef ARB_HOLD_LIMIT_EN
                m_hold++;
                if (m_hold == MAX_HOLD) begin
                    if (rest != 0) pass_on = 1'b1;
                    else           m_hold  = 0;
                end
`endif
            end else if (rest != 0) begin
                pass_on = 1'b1;
            end else begin
                m_ptr = (m_own + 1) % 4;
                m_own = -1;
            end
            if (pass_on) begin
                m_ptr  = (m_own + 1) % 4;
                m_own  = first_from(r, m_ptr);
                m_hold = 0;
            end
        end
    endtask

    // Apply inputs for one cycle, advance the model, then compare just after the edge.
    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        model_edge(r, rs);
        @(posedge clk);
        #1;
        chk("gnt",   {28'b0, gnt},       (m_own < 0) ? 32'h0 : (32'h1 << m_own));
        chk("idx",   {30'b0, gnt_idx},   (m_own < 0) ? 32'h0 : 32'(m_own));
        chk("valid", {31'b0, gnt_valid}, (m_own < 0) ? 32'h0 : 32'h1);
    endtask

    initial begin
        logic [3:0] r;
        req = 4'b0000;
        rst = 1'b1;

        // Reset held with all requesting.
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1);
            chk("rst_gnt", {28'b0, gnt}, 32'h0);
            chk("rst_vld", {31'b0, gnt_valid}, 32'h0);
        end

        // Single request, release, then ptr favours master 3 over master 0.
        step(4'b0100, 1'b0);
        chk("single_gnt", {28'b0, gnt}, 32'h4);
        chk("single_idx", {30'b0, gnt_idx}, 32'h2);
        step(4'b0000, 1'b0);
        chk("release", {28'b0, gnt}, 32'h0);
        step(4'b1001, 1'b0);
        chk("ptr_pri", {28'b0, gnt}, 32'h8);
        step(4'b0000, 1'b0);

        // Round-robin with one-cycle ownership, after a fresh reset.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b0);
        chk("rr0", {28'b0, gnt}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            r = 4'b1111 & ~gnt;
            step(r, 1'b0);
            chk("rr_seq", {28'b0, gnt}, 32'h1 << (i % 4));
            chk("rr_vld", {31'b0, gnt_valid}, 32'h1);
        end

        // Back-to-back: master 1 owns, req 0011 -> 1001 hands to 3.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0011, 1'b0);
        chk("b2b_own", {28'b0, gnt}, 32'h2);
        step(4'b1001, 1'b0);
        chk("b2b_gnt", {28'b0, gnt}, 32'h8);
        chk("b2b_vld", {31'b0, gnt_valid}, 32'h1);

        // Reset mid-grant: master 2 owns, reset, then ptr back to 0.
        step(4'b0100, 1'b0);
        chk("mid_own", {28'b0, gnt}, 32'h4);
        step(4'b1111, 1'b1);
        chk("mid_rst", {28'b0, gnt}, 32'h0);
        step(4'b1111, 1'b0);
        chk("post_rst", {28'b0, gnt}, 32'h1);

        // Constant 0011 and 0001: hold-limit behaviour follows the build.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) step(4'b0011, 1'b0);
        step(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) step(4'b0001, 1'b0);
        chk("solo_hold", {28'b0, gnt}, 32'h1);

        // Random: req held for random stretches, rare resets.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r, ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
